// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the memory-mapped countdown timer:
//               register offsets (Addr[3:2]), CTRL bit positions, mode
//               encodings and the timer state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

   // Register offsets as seen on Addr[3:2]
   localparam logic [1:0] ADDR_CTRL   = 2'b00;
   localparam logic [1:0] ADDR_PRESET = 2'b01;
   localparam logic [1:0] ADDR_COUNT  = 2'b10;

   // CTRL bit positions
   localparam int CTRL_EN       = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM       = 3;

   // Mode encodings; the two unused encodings behave as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // Timer sequencing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } timer_state_e;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
// Module      : timer_dev
// Description : Programmable countdown timer on the system bus. Holds the
//               CTRL / PRESET / COUNT registers, sequences the countdown and
//               raises a level interrupt request toward CP0.
//
// Ports       : clk    - system clock, rising-edge state updates
//               reset  - synchronous reset, active low (0 = reset)
//               Addr   - word address [31:2]; only Addr[3:2] is decoded
//               WE     - write enable, already qualified by device select
//               Din    - write data
//               Dout   - combinational read data for the current Addr
//               IRQ    - interrupt request, CTRL.IM & pending flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module timer_dev
   import timer_pkg::*;
#(
   parameter logic [31:0] PRESET_RST = 32'd0,
   parameter logic [31:0] CTRL_WMASK = 32'h0000_000F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   timer_state_e state_q, state_d;
   logic [31:0]  ctrl_q, ctrl_d;
   logic [31:0]  preset_q, preset_d;
   logic [31:0]  count_q, count_d;
   logic         irq_pend_q, irq_pend_d;

   logic         w_en;
   logic         w_reload;
   logic         w_fire;
   logic [1:0]   w_reg_sel;
   logic         w_unused_addr;

   assign w_reg_sel     = Addr[1:0];
   // Upper address bits are decoded by the bridge, not here
   assign w_unused_addr = ^Addr[29:2];

   assign w_en     = ctrl_q[CTRL_EN];
   assign w_reload = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);

   // ------------------------------------------------------------------------
   // Next-state logic: countdown sequencing, then CPU register writes.
   // The CPU write is applied last so that a CTRL write in the same cycle
   // as the one-shot En clear takes precedence.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_pend_d = irq_pend_q;
      w_fire     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_en) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            // Load completes even if En was cleared meanwhile
            count_d = preset_q;
            state_d = ST_CNT;
         end

         ST_CNT: begin
            if (!w_en) begin
               state_d = ST_IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               // Terminal count; a zero preset also lands here so the
               // counter never wraps below zero
               count_d    = 32'd0;
               irq_pend_d = 1'b1;
               w_fire     = 1'b1;
               state_d    = ST_INT;
            end
         end

         ST_INT: begin
            if (w_reload) begin
               irq_pend_d = 1'b0;
               state_d    = ST_LOAD;
            end else begin
               ctrl_d[CTRL_EN] = 1'b0;
               state_d         = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (WE) begin
         case (w_reg_sel)
            ADDR_CTRL: begin
               ctrl_d = Din & CTRL_WMASK;
               // Acknowledge clears the pending flag, but a terminal count
               // arriving on the very same edge is not lost
               irq_pend_d = w_fire;
            end
            ADDR_PRESET: begin
               // Only latched here; a running count picks it up at next load
               preset_d = Din;
            end
            default: begin
               // COUNT is read-only and the last slot is reserved
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= 32'd0;
         preset_q   <= PRESET_RST;
         count_q    <= 32'd0;
         irq_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_pend_q <= irq_pend_d;
      end
   end

   // ------------------------------------------------------------------------
   // Zero-latency read mux and interrupt output
   // ------------------------------------------------------------------------
   always_comb begin
      Dout = 32'd0;
      case (w_reg_sel)
         ADDR_CTRL:   Dout = ctrl_q;
         ADDR_PRESET: Dout = preset_q;
         ADDR_COUNT:  Dout = count_q;
         default:     Dout = 32'd0;
      endcase
   end

   assign IRQ = ctrl_q[CTRL_IM] & irq_pend_q;

endmodule : timer_dev
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_dev
// Description : Self-checking bench for timer_dev. A behavioural model of the
//               register map and countdown timing runs beside the DUT and is
//               compared every cycle; directed sequences add literal checks
//               with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_dev;

   logic        clk;
   logic        reset;
   logic [29:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int checks;
   int errors;
   bit cmp_en;

   timer_dev #(
      .PRESET_RST (32'd0),
      .CTRL_WMASK (32'h0000_000F)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Behavioural model. Phase: 0 idle, 1 about to load, 2 counting,
   // 3 terminal count reached.
   // ------------------------------------------------------------------------
   int          m_phase;
   logic [31:0] m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   bit          m_pend;

   always @(posedge clk) begin
      logic [31:0] nxt_ctrl;
      bit          nxt_pend;
      bit          fired;
      if (!reset) begin
         m_phase  = 0;
         m_ctrl   = 32'd0;
         m_preset = 32'd0;
         m_count  = 32'd0;
         m_pend   = 1'b0;
      end else begin
         nxt_ctrl = m_ctrl;
         nxt_pend = m_pend;
         fired    = 1'b0;
         if (m_phase == 0) begin
            if (m_ctrl[0]) m_phase = 1;
         end else if (m_phase == 1) begin
            m_count = m_preset;
            m_phase = 2;
         end else if (m_phase == 2) begin
            if (!m_ctrl[0]) m_phase = 0;
            else if (m_count >= 2) m_count = m_count - 1;
            else begin
               m_count  = 0;
               nxt_pend = 1'b1;
               fired    = 1'b1;
               m_phase  = 3;
            end
         end else begin
            if (m_ctrl[2:1] == 2'b01) begin
               nxt_pend = 1'b0;
               m_phase  = 1;
            end else begin
               nxt_ctrl[0] = 1'b0;
               m_phase     = 0;
            end
         end
         if (WE && Addr[1:0] == 2'd0) begin
            nxt_ctrl = Din & 32'h0000_000F;
            nxt_pend = fired;
         end
         if (WE && Addr[1:0] == 2'd1) m_preset = Din;
         m_ctrl = nxt_ctrl;
         m_pend = nxt_pend;
      end
   end

   function automatic logic [31:0] model_dout(input logic [1:0] sel);
      case (sel)
         2'd0:    return m_ctrl;
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_dout", Dout, model_dout(Addr[1:0]));
         chk("model_irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_pend});
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] d);
      Addr = {28'd0, off};
      Din  = d;
      WE   = 1'b1;
      tick();
      WE   = 1'b0;
      Din  = 32'd0;
   endtask

   task automatic rd(input logic [1:0] off, input string nm, input logic [31:0] exp);
      Addr = {28'd0, off};
      #1;
      chk(nm, Dout, exp);
   endtask

   task automatic irq_is(input string nm, input logic exp);
      chk(nm, {31'd0, IRQ}, {31'd0, exp});
   endtask

   // ------------------------------------------------------------------------
   // Directed sequences
   // ------------------------------------------------------------------------
   initial begin
      checks = 0;
      errors = 0;
      cmp_en = 1'b0;
      reset  = 1'b0;
      WE     = 1'b0;
      Addr   = 30'd0;
      Din    = 32'd0;

      // Reset held for two edges
      tick();
      cmp_en = 1'b1;
      tick();
      rd(2'd0, "rst_ctrl", 32'd0);
      rd(2'd2, "rst_count", 32'd0);
      irq_is("rst_irq", 1'b0);
      reset = 1'b1;
      tick();
      rd(2'd1, "rst_preset", 32'd0);

      // One-shot: PRESET=3, CTRL=En|IM
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h9);
      Addr = 30'd2;
      tick();
      tick(); rd(2'd2, "os_count3", 32'd3);
      tick(); rd(2'd2, "os_count2", 32'd2);
      tick(); rd(2'd2, "os_count1", 32'd1); irq_is("os_irq_early", 1'b0);
      tick(); rd(2'd2, "os_count0", 32'd0); irq_is("os_irq_fire", 1'b1);
      tick(); rd(2'd0, "os_ctrl_en_clr", 32'h8); irq_is("os_irq_hold1", 1'b1);
      tick(); tick(); irq_is("os_irq_hold2", 1'b1);
      wr(2'd0, 32'h0);
      irq_is("os_irq_ack", 1'b0);
      tick();

      // Auto-reload: PRESET=2 gives a 4-cycle period
      wr(2'd1, 32'd2);
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 13; k++) begin
         tick();
         rd(2'd2, "ar_count",
            (k % 4 == 2) ? 32'd2 : (k % 4 == 3) ? 32'd1 : 32'd0);
         irq_is("ar_irq", (k % 4 == 0));
      end
      wr(2'd0, 32'h0);
      tick(); tick(); tick();

      // Masked interrupt: pending sets but IRQ stays low
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h1);
      tick(); tick(); tick();
      rd(2'd2, "mask_count0", 32'd0);
      irq_is("mask_irq_low", 1'b0);
      tick();
      wr(2'd0, 32'h8);
      irq_is("mask_ack_irq", 1'b0);
      tick(); tick();
      irq_is("mask_ack_irq_later", 1'b0);
      wr(2'd0, 32'h0);

      // Zero preset fires on the first counting edge
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      tick(); tick();
      irq_is("p0_irq_not_yet", 1'b0);
      tick();
      irq_is("p0_irq_fire", 1'b1);
      rd(2'd2, "p0_count", 32'd0);
      wr(2'd0, 32'h0);
      tick();

      // Pause / resume, ignored COUNT write, reserved read
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h1);
      for (int k = 0; k < 5; k++) tick();
      wr(2'd0, 32'h0);
      rd(2'd2, "pause_count6", 32'd6);
      for (int k = 0; k < 5; k++) begin
         tick();
         rd(2'd2, "pause_hold", 32'd6);
      end
      wr(2'd0, 32'h1);
      tick(); tick();
      rd(2'd2, "resume_reload", 32'd10);
      wr(2'd2, 32'h55);
      rd(2'd2, "count_wr_ignored", 32'd9);
      rd(2'd3, "reserved_read", 32'd0);
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd3, "reserved_after_wr", 32'd0);
      wr(2'd0, 32'h0);

      // PRESET write while running, then reset mid-count
      wr(2'd1, 32'd100);
      wr(2'd0, 32'h9);
      for (int k = 0; k < 20; k++) tick();
      rd(2'd2, "run_count82", 32'd82);
      wr(2'd1, 32'd50);
      rd(2'd2, "preset_no_disturb", 32'd81);
      rd(2'd1, "preset_new", 32'd50);
      reset = 1'b0;
      tick();
      rd(2'd2, "midrst_count", 32'd0);
      rd(2'd0, "midrst_ctrl", 32'd0);
      irq_is("midrst_irq", 1'b0);
      reset = 1'b1;
      tick(); tick();

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_timer_dev
`default_nettype wire
